// File: rtl/fixed_point_pkg.sv
// Shared types for the fixed-point lane adders: controller states and
// the per-lane result record.
package fixed_point_pkg;

  // Widest lane value the shared result record can carry.
  localparam int unsigned MaxLaneWidth = 64;

  typedef enum logic [0:0] {
    StIdle,
    StCalc
  } state_t;

  typedef struct packed {
    logic [MaxLaneWidth-1:0] value;
    logic                    ovf;
  } lane_result_t;

endpackage

// File: rtl/fixed_point_lane_alu.sv
// Combinational signed add/subtract of one fixed-point lane with
// selectable saturate-or-wrap overflow handling.
module fixed_point_lane_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic [WIDTH-1:0] value,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] sum;

  always_comb begin
    a_ext = {a[WIDTH-1], a};
    b_ext = {b[WIDTH-1], b};
    sum   = sub ? (a_ext - b_ext) : (a_ext + b_ext);
    // One guard bit: the true sign disagrees with the result sign on overflow.
    ovf   = sum[WIDTH] ^ sum[WIDTH-1];
    if (ovf && sat) begin
      value = sum[WIDTH] ? SatMin : SatMax;
    end else begin
      value = sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fixed_point_vector_adder.sv
// Multi-lane fixed-point adder/subtractor: latches LANES operand pairs on
// start and runs them one lane per cycle through a shared lane ALU.
module fixed_point_vector_adder
  import fixed_point_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned FBITS = 4,
  parameter int unsigned LANES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_sub,
  input  logic                   i_sat,
  input  logic [WIDTH*LANES-1:0] i_operandA,
  input  logic [WIDTH*LANES-1:0] i_operandB,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_valid,
  output logic                   o_overflow,
  output logic [LANES-1:0]       o_ovf_mask,
  output logic [WIDTH*LANES-1:0] o_val
);

  localparam int unsigned IdxW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(LANES - 1);

  // FBITS only labels the format; reject meaningless builds at elaboration.
  if (FBITS >= WIDTH || LANES < 1 || WIDTH < 2 || WIDTH > MaxLaneWidth) begin : g_bad_params
    $error("fixed_point_vector_adder: unsupported WIDTH/FBITS/LANES");
  end

  state_t                 state_q, state_d;
  logic [WIDTH*LANES-1:0] a_q, a_d, b_q, b_d, val_q, val_d;
  logic [LANES-1:0]       mask_q, mask_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   sub_q, sub_d, sat_q, sat_d;
  logic                   busy_q, busy_d, done_q, done_d;
  logic                   valid_q, valid_d, ovf_q, ovf_d;

  logic [WIDTH-1:0]       lane_a, lane_b, lane_value;
  logic                   lane_ovf;

  assign lane_a = a_q[idx_q*WIDTH +: WIDTH];
  assign lane_b = b_q[idx_q*WIDTH +: WIDTH];

  fixed_point_lane_alu #(
    .WIDTH(WIDTH)
  ) u_lane_alu (
    .a    (lane_a),
    .b    (lane_b),
    .sub  (sub_q),
    .sat  (sat_q),
    .value(lane_value),
    .ovf  (lane_ovf)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    val_d   = val_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    sub_d   = sub_q;
    sat_d   = sat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          a_d     = i_operandA;
          b_d     = i_operandB;
          sub_d   = i_sub;
          sat_d   = i_sat;
          val_d   = '0;
          mask_d  = '0;
          ovf_d   = 1'b0;
          valid_d = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = StCalc;
        end
      end
      StCalc: begin
        val_d[idx_q*WIDTH +: WIDTH] = lane_value;
        mask_d[idx_q]               = lane_ovf;
        if (idx_q == LastIdx) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          valid_d = 1'b1;
          ovf_d   = |mask_d;
          state_d = StIdle;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      val_q   <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      sub_q   <= 1'b0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      val_q   <= val_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      sub_q   <= sub_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_valid    = valid_q;
  assign o_overflow = ovf_q;
  assign o_ovf_mask = mask_q;
  assign o_val      = val_q;

endmodule

// File: tb/tb_fixed_point_vector_adder.sv
// Self-checking bench for fixed_point_vector_adder: vector table with a
// result scoreboard, handshake corner sequences and a single-lane build.
module tb_fixed_point_vector_adder;
  import fixed_point_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        sat;
    logic [31:0] exp_val;
    logic [3:0]  exp_mask;
  } vec_t;

  typedef struct {
    logic [31:0] val;
    logic [3:0]  mask;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, sub = 1'b0, sat = 1'b0;
  logic [31:0] opa = '0, opb = '0;
  logic        busy, done, valid, overflow;
  logic [3:0]  mask;
  logic [31:0] val;

  logic        start1 = 1'b0, sub1 = 1'b0, sat1 = 1'b0;
  logic [7:0]  a1 = '0, b1 = '0;
  logic        busy1, done1, valid1, overflow1;
  logic [0:0]  mask1;
  logic [7:0]  val1;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[8];
  exp_t sb[$];

  always #5 clk = ~clk;

  fixed_point_vector_adder #(.WIDTH(8), .FBITS(4), .LANES(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_sub(sub), .i_sat(sat),
    .i_operandA(opa), .i_operandB(opb), .o_busy(busy), .o_done(done), .o_valid(valid),
    .o_overflow(overflow), .o_ovf_mask(mask), .o_val(val)
  );

  fixed_point_vector_adder #(.WIDTH(8), .FBITS(4), .LANES(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_sub(sub1), .i_sat(sat1),
    .i_operandA(a1), .i_operandB(b1), .o_busy(busy1), .o_done(done1), .o_valid(valid1),
    .o_overflow(overflow1), .o_ovf_mask(mask1), .o_val(val1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
    check({tag, " valid"}, 64'(valid), 64'd0);
    check({tag, " overflow"}, 64'(overflow), 64'd0);
    check({tag, " mask"}, 64'(mask), 64'd0);
    check({tag, " val"}, 64'(val), 64'd0);
  endtask

  // Drive a table vector for one edge and push its expected result.
  task automatic launch(input int i);
    opa   = vecs[i].a;
    opb   = vecs[i].b;
    sub   = vecs[i].sub;
    sat   = vecs[i].sat;
    start = 1'b1;
    sb.push_back('{val: vecs[i].exp_val, mask: vecs[i].exp_mask});
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done, then pops and compares the scoreboard entry.
  task automatic await_result(input int exp_lat, input string tag);
    int   n = 0;
    int   busy_cnt = 0;
    exp_t e;
    while (!done && n < 50) begin
      if (busy) busy_cnt++;
      n++;
      @(negedge clk);
    end
    check({tag, " done latency"}, 64'(n), 64'(exp_lat));
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat));
    check({tag, " busy at done"}, 64'(busy), 64'd0);
    check({tag, " valid at done"}, 64'(valid), 64'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " val"}, 64'(val), 64'(e.val));
      check({tag, " mask"}, 64'(mask), 64'(e.mask));
      check({tag, " overflow"}, 64'(overflow), 64'(|e.mask));
    end
  endtask

  task automatic check_done_pulse(input string tag);
    @(negedge clk);
    check({tag, " done pulse end"}, 64'(done), 64'd0);
    check({tag, " valid hold"}, 64'(valid), 64'd1);
    check({tag, " idle busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    lane_result_t r1;
    vecs[0] = '{32'h00F01018, 32'h7F101008, 1'b0, 1'b0, 32'h7F002020, 4'h0};
    vecs[1] = '{32'h00000070, 32'h00000020, 1'b0, 1'b1, 32'h0000007F, 4'h1};
    vecs[2] = '{32'h00000070, 32'h00000020, 1'b0, 1'b0, 32'h00000090, 4'h1};
    vecs[3] = '{32'h00800000, 32'h00010000, 1'b1, 1'b1, 32'h00800000, 4'h4};
    vecs[4] = '{32'h00800000, 32'h00010000, 1'b1, 1'b0, 32'h007F0000, 4'h4};
    vecs[5] = '{32'h00000000, 32'h00008000, 1'b1, 1'b1, 32'h00007F00, 4'h2};
    vecs[6] = '{32'h807FC005, 32'h8001C0FB, 1'b0, 1'b1, 32'h807F8000, 4'hC};
    vecs[7] = '{32'h00000010, 32'h00000020, 1'b1, 1'b0, 32'h000000F0, 4'h0};

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    check("reset lanes1 val", 64'(val1), 64'd0);
    check("reset lanes1 valid", 64'(valid1), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      launch(i);
      await_result(4, $sformatf("vec%0d", i));
      check_done_pulse($sformatf("vec%0d", i));
    end

    // Start pulse two edges into a transaction must be dropped, not queued.
    launch(0);
    @(negedge clk);
    opa   = vecs[1].a;
    opb   = vecs[1].b;
    sat   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    await_result(2, "ignore");
    repeat (2) @(negedge clk);
    check("ignore no requeue busy", 64'(busy), 64'd0);
    check("ignore valid hold", 64'(valid), 64'd1);
    check("ignore val hold", 64'(val), 64'(vecs[0].exp_val));

    // Back-to-back: start asserted during the done cycle.
    launch(1);
    await_result(4, "sod first");
    launch(2);
    check("sod valid drop", 64'(valid), 64'd0);
    check("sod busy", 64'(busy), 64'd1);
    check("sod cleared val", 64'(val), 64'd0);
    await_result(4, "sod second");
    check_done_pulse("sod second");

    // Asynchronous reset mid-transaction, then a clean restart.
    launch(6);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset busy", 64'(busy), 64'd0);
    launch(6);
    await_result(4, "post reset");
    check_done_pulse("post reset");

    // Single-lane build.
    r1    = '{value: 64'h7F, ovf: 1'b1};
    a1    = 8'h7F;
    b1    = 8'h01;
    sat1  = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("lanes1 busy", 64'(busy1), 64'd1);
    check("lanes1 early done", 64'(done1), 64'd0);
    @(negedge clk);
    check("lanes1 done", 64'(done1), 64'd1);
    check("lanes1 busy end", 64'(busy1), 64'd0);
    check("lanes1 valid", 64'(valid1), 64'd1);
    check("lanes1 val", 64'(val1), 64'(r1.value[7:0]));
    check("lanes1 mask", 64'(mask1), 64'(r1.ovf));
    check("lanes1 overflow", 64'(overflow1), 64'(r1.ovf));
    @(negedge clk);
    check("lanes1 done pulse end", 64'(done1), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
